// File: rtl/div_sequencer.sv
// Sequential 32-bit restoring divider: one quotient bit per cycle through a single Sub_32.
// Signed operation is compiled in only when DIV_SEQUENCER_SIGNED_EN is defined.

module Sub_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] diff,
  output logic        c_out
);
  logic [32:0] sum;

  // c_in is a borrow-in; c_out is the inverted borrow (1 means a >= b unsigned)
  assign sum   = {1'b0, a} + {1'b0, ~b} + {32'd0, ~c_in};
  assign diff  = sum[31:0];
  assign c_out = sum[32];
endmodule

module div_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        div_signed,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] RUN  = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]  state;
  logic [31:0] dvd_cap, dvs_cap;
  logic        sgn_cap;
  logic [31:0] rem, quo, dvs;
  logic [4:0]  cnt;
  logic        q_neg, r_neg;
  logic        sgn_en;

`ifdef DIV_SEQUENCER_SIGNED_EN
  assign sgn_en = div_signed;
`else
  logic unused_div_signed;
  assign unused_div_signed = div_signed;
  assign sgn_en = 1'b0;
`endif

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic s);
    return (s && v[31]) ? neg32(v) : v;
  endfunction

  logic [31:0] shifted, diff;
  logic        out_bit, c_out, take;

  // The dividend drains out of quo's MSB while quotient bits enter at its LSB
  assign shifted = {rem[30:0], quo[31]};
  assign out_bit = rem[31];
  assign take    = c_out | out_bit;

  Sub_32 u_sub (
    .a    (shifted),
    .b    (dvs),
    .c_in (1'b0),
    .diff (diff),
    .c_out(c_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dvd_cap     <= '0;
      dvs_cap     <= '0;
      sgn_cap     <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dvd_cap <= dividend;
          dvs_cap <= divisor;
          sgn_cap <= sgn_en;
          cnt     <= '0;
          state   <= LOAD;
        end
        LOAD: if (dvs_cap == 32'd0) begin
          // Zero divisor lingers one extra LOAD cycle so its done lands two edges after LOAD entry
          if (cnt == 5'd0) begin
            cnt <= 5'd1;
          end else begin
            quotient    <= '1;
            remainder   <= dvd_cap;
            div_by_zero <= 1'b1;
            state       <= DONE;
          end
        end else begin
          rem   <= '0;
          quo   <= mag32(dvd_cap, sgn_cap);
          dvs   <= mag32(dvs_cap, sgn_cap);
          cnt   <= '0;
          q_neg <= sgn_cap & (dvd_cap[31] ^ dvs_cap[31]);
          r_neg <= sgn_cap & dvd_cap[31];
          state <= RUN;
        end
        RUN: begin
          rem <= take ? diff : shifted;
          quo <= {quo[30:0], take};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          quotient    <= q_neg ? neg32(quo) : quo;
          remainder   <= r_neg ? neg32(rem) : rem;
          div_by_zero <= 1'b0;
          state       <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == LOAD) || (state == RUN) || (state == FIX);
  assign done = (state == DONE);
endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: table of divisions checked through a result scoreboard,
// plus back-to-back issue, mid-run reset and ignored-start sequences.

module tb_div_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        div_signed = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  div_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_signed (div_signed),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          start_cyc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  exp_t sb[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check32("quotient", quotient, e.q);
        check32("remainder", remainder, e.r);
        check32("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        check32("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
      end
    end
  end

  task automatic issue(input vec_t v);
    @(negedge clk);
    dividend   = v.a;
    divisor    = v.b;
    div_signed = v.s;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = ~v.a;
    divisor  = ~v.b;
    sb.push_back('{v.q, v.r, v.dbz, cyc, (v.b == 32'd0) ? 2 : 34});
    check32("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d results outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  vec_t tbl[$];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;

    tbl.push_back('{32'd12,         32'd2,          1'b0, 32'd6,          32'd0,          1'b0});
    tbl.push_back('{32'hFFFFFFFF,   32'd7,          1'b0, 32'h24924924,   32'd3,          1'b0});
    tbl.push_back('{32'd100,        32'd0,          1'b0, 32'hFFFFFFFF,   32'd100,        1'b1});
    tbl.push_back('{32'd1000,       32'd1000,       1'b0, 32'd1,          32'd0,          1'b0});
    tbl.push_back('{32'd5,          32'd7,          1'b0, 32'd0,          32'd5,          1'b0});
    tbl.push_back('{32'hFFFFFFFF,   32'h80000001,   1'b0, 32'd1,          32'h7FFFFFFE,   1'b0});
    tbl.push_back('{32'hFFFFFFFB,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1});
    tbl.push_back('{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0});
`ifdef DIV_SEQUENCER_SIGNED_EN
    tbl.push_back('{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0});
    tbl.push_back('{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0});
    tbl.push_back('{32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0});
    tbl.push_back('{32'hFFFFFFF8,   32'hFFFFFFFD,   1'b1, 32'd2,          32'hFFFFFFFE,   1'b0});
`else
    tbl.push_back('{32'hFFFFFFF9,   32'd2,          1'b1, 32'h7FFFFFFC,   32'd1,          1'b0});
    tbl.push_back('{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'd0,          32'h80000000,   1'b0});
`endif

    repeat (3) @(posedge clk);
    #1;
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_done", {31'd0, done}, 32'd0);
    check32("reset_quotient", quotient, 32'd0);
    check32("reset_remainder", remainder, 32'd0);
    check32("reset_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      issue(tbl[i]);
      wait_drain(60);
    end

    // Start held high from issue through DONE: operands swapped mid-run must not matter,
    // and the second request is taken in the IDLE cycle right after DONE.
    @(negedge clk);
    dividend   = 32'd12;
    divisor    = 32'd2;
    div_signed = 1'b0;
    start      = 1'b1;
    @(posedge clk);
    #1;
    n0 = cyc;
    sb.push_back('{32'd6, 32'd0, 1'b0, n0, 34});
    sb.push_back('{32'd6, 32'd2, 1'b0, n0 + 36, 34});
    dividend = 32'd20;
    divisor  = 32'd3;
    repeat (36) @(posedge clk);
    #1;
    start = 1'b0;
    check32("b2b_busy_second", {31'd0, busy}, 32'd1);
    wait_drain(80);

    // Asynchronous reset during iteration 10 abandons the operation silently
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check32("midreset_busy", {31'd0, busy}, 32'd0);
    check32("midreset_done", {31'd0, done}, 32'd0);
    check32("midreset_quotient", quotient, 32'd0);
    check32("midreset_remainder", remainder, 32'd0);
    check32("midreset_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    dividend = 32'd12;
    divisor  = 32'd2;
    start    = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back('{32'd6, 32'd0, 1'b0, cyc, 34});
    check32("post_reset_accept_busy", {31'd0, busy}, 32'd1);
    wait_drain(60);

    repeat (5) @(posedge clk);
    #1;
    check32("final_idle_busy", {31'd0, busy}, 32'd0);
    check32("final_held_quotient", quotient, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
